// File: rtl/bitonic_topk_drain.sv
// bitonic_topk_drain
// Consumer end of a bitonic sorter. Each sorter output pulse delivers one
// sorted vector. The block keeps its leading TOPK elements in one of two
// ping-pong slots and sends them out one element at a time on a valid/ready
// stream, rank 0 first. The sorter cannot be stalled, so when both slots are
// occupied a new vector is dropped and a sticky overflow flag is raised.
module bitonic_topk_drain #(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 16,
    parameter int TOPK       = 4,
    parameter int RANKW      = (TOPK > 1) ? $clog2(TOPK) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 vec_valid_i,
    input  logic [DATALENGTH-1:0][DATAWIDTH-1:0] x_i,
    input  logic                                 clr_ovf_i,
    output logic                                 y_valid_o,
    input  logic                                 y_ready_i,
    output logic [DATAWIDTH-1:0]                 y_o,
    output logic [RANKW-1:0]                     y_rank_o,
    output logic                                 y_last_o,
    output logic                                 y_vec_id_o,
    output logic                                 busy_o,
    output logic                                 overflow_o
);

    localparam logic [RANKW-1:0] RANK_LAST = RANKW'(TOPK - 1);

    // Slot storage: two vectors of TOPK elements, not reset.
    logic [DATAWIDTH-1:0] slot_q [2][TOPK];

    logic [1:0]       full_q,   full_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [RANKW-1:0] rank_q,   rank_d;
    logic             ovf_q,    ovf_d;

    logic             head_valid_s;
    logic             xfer_s;
    logic             last_s;
    logic             free_s;
    logic             accept_s;
    logic             drop_s;

    // Handshake decode, capture/drop decision and next-state computation.
    always_comb begin
        head_valid_s = full_q[rd_ptr_q];
        xfer_s       = head_valid_s & y_ready_i;
        last_s       = (rank_q == RANK_LAST);
        free_s       = xfer_s & last_s;
        // A full write slot is still usable when its last element leaves
        // on this very edge (only possible when both pointers coincide).
        accept_s     = vec_valid_i &
                       (~full_q[wr_ptr_q] | (free_s & (rd_ptr_q == wr_ptr_q)));
        drop_s       = vec_valid_i & ~accept_s;

        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rank_d   = rank_q;
        ovf_d    = ovf_q;

        // Drain side: advance rank, or retire the slot on its last element.
        if (free_s) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
            rank_d           = {RANKW{1'b0}};
        end else if (xfer_s) begin
            rank_d = rank_q + {{(RANKW-1){1'b0}}, 1'b1};
        end else begin
            rank_d = rank_q;
        end

        // Fill side: applied after the drain so a same-slot refill wins.
        if (accept_s) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // Sticky overflow: a new drop outranks a clear request.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q   <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rank_q   <= {RANKW{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rank_q   <= rank_d;
            ovf_q    <= ovf_d;
        end
    end

    // Slot data capture; only the leading TOPK elements are kept.
    always_ff @(posedge clk_i) begin
        if (accept_s && !rst_i) begin
            for (int i = 0; i < TOPK; i++) begin
                slot_q[wr_ptr_q][i] <= x_i[i];
            end
        end
    end

    // Output stage: every output is a function of registered state only.
    always_comb begin
        y_valid_o  = head_valid_s;
        y_rank_o   = rank_q;
        y_vec_id_o = rd_ptr_q;
        y_last_o   = head_valid_s & last_s;
        busy_o     = full_q[0] | full_q[1];
        overflow_o = ovf_q;
        if (head_valid_s) begin
            y_o = slot_q[rd_ptr_q][rank_q];
        end else begin
            y_o = {DATAWIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_bitonic_topk_drain.sv
// Directed bench for bitonic_topk_drain: a per-cycle table of inputs and
// expected outputs, followed by a streaming sequence with a small model.
module tb_bitonic_topk_drain;

    localparam int DW = 8;
    localparam int DL = 16;
    localparam int K  = 4;
    localparam int RW = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   vv  = 1'b0;
    logic [DL-1:0][DW-1:0]  x   = '0;
    logic                   clr = 1'b0;
    logic                   rdy = 1'b0;
    logic                   y_valid;
    logic [DW-1:0]          y;
    logic [RW-1:0]          y_rank;
    logic                   y_last;
    logic                   y_id;
    logic                   busy;
    logic                   ovf;

    int total = 0;
    int bad   = 0;

    bitonic_topk_drain #(.DATAWIDTH(DW), .DATALENGTH(DL), .TOPK(K)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .vec_valid_i (vv),
        .x_i         (x),
        .clr_ovf_i   (clr),
        .y_valid_o   (y_valid),
        .y_ready_i   (rdy),
        .y_o         (y),
        .y_rank_o    (y_rank),
        .y_last_o    (y_last),
        .y_vec_id_o  (y_id),
        .busy_o      (busy),
        .overflow_o  (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, vv;
        logic [7:0] x0, x1, x2, x3;
        logic       rdy, clr;
        logic       ev;
        logic [7:0] ey;
        logic [1:0] er;
        logic       el, eid, eb, eo;
    } step_t;

    step_t tbl[$];

    task automatic add(input logic r, v, input logic [7:0] a, b, c, d,
                       input logic rd, cl, ev, input logic [7:0] ey,
                       input logic [1:0] er, input logic el, eid, eb, eo);
        step_t s;
        s.rst = r;  s.vv = v;  s.x0 = a;  s.x1 = b;  s.x2 = c;  s.x3 = d;
        s.rdy = rd; s.clr = cl; s.ev = ev; s.ey = ey; s.er = er;
        s.el = el;  s.eid = eid; s.eb = eb; s.eo = eo;
        tbl.push_back(s);
    endtask

    // Sorted-vector builder; elements beyond the top four are filler.
    function automatic logic [DL-1:0][DW-1:0] mkx(input logic [7:0] a, b, c, d);
        logic [DL-1:0][DW-1:0] v;
        for (int i = 0; i < DL; i++) v[i] = 8'h55;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    task automatic chk(input string nm, input int step, input logic [31:0] got, exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h exp=%0h", nm, step, got, exp);
        end
    endtask

    task automatic chk_out(input int step, input logic ev, input logic [7:0] ey,
                           input logic [1:0] er, input logic el, eid, eb, eo);
        chk("y_valid", step, 32'(y_valid), 32'(ev));
        chk("y",       step, 32'(y),       32'(ey));
        chk("y_rank",  step, 32'(y_rank),  32'(er));
        chk("y_last",  step, 32'(y_last),  32'(el));
        chk("y_vec_id",step, 32'(y_id),    32'(eid));
        chk("busy",    step, 32'(busy),    32'(eb));
        chk("overflow",step, 32'(ovf),     32'(eo));
    endtask

    initial begin
        // ---- single vector, full-speed drain ----
        add(1'b1,1'b0,8'h00,8'h00,8'h00,8'h00,1'b0,1'b0, 1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,8'hF0,8'hC3,8'h80,8'h11,1'b1,1'b0, 1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'hF0,2'd0,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'hC3,2'd1,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h80,2'd2,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h11,2'd3,1'b1,1'b0,1'b1,1'b0);
        // ---- stall for five cycles, then drain ----
        add(1'b0,1'b1,8'hA1,8'hB2,8'hC3,8'hD4,1'b0,1'b0, 1'b0,8'h00,2'd0,1'b0,1'b1,1'b0,1'b0);
        for (int i = 0; i < 5; i++)
            add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b0,1'b0, 1'b1,8'hA1,2'd0,1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'hA1,2'd0,1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'hB2,2'd1,1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'hC3,2'd2,1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'hD4,2'd3,1'b1,1'b1,1'b1,1'b0);
        // ---- three back-to-back vectors, third dropped ----
        add(1'b0,1'b1,8'h01,8'h02,8'h03,8'h04,1'b0,1'b0, 1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,8'h11,8'h12,8'h13,8'h14,1'b0,1'b0, 1'b1,8'h01,2'd0,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b1,8'h21,8'h22,8'h23,8'h24,1'b0,1'b0, 1'b1,8'h01,2'd0,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h01,2'd0,1'b0,1'b0,1'b1,1'b1);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h02,2'd1,1'b0,1'b0,1'b1,1'b1);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h03,2'd2,1'b0,1'b0,1'b1,1'b1);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h04,2'd3,1'b1,1'b0,1'b1,1'b1);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h11,2'd0,1'b0,1'b1,1'b1,1'b1);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h12,2'd1,1'b0,1'b1,1'b1,1'b1);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h13,2'd2,1'b0,1'b1,1'b1,1'b1);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h14,2'd3,1'b1,1'b1,1'b1,1'b1);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b0,1'b1, 1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b1);
        // ---- both full, refill on the edge the head slot retires ----
        add(1'b0,1'b1,8'h31,8'h32,8'h33,8'h34,1'b0,1'b0, 1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,8'h41,8'h42,8'h43,8'h44,1'b1,1'b0, 1'b1,8'h31,2'd0,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h32,2'd1,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h33,2'd2,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b1,8'h51,8'h52,8'h53,8'h54,1'b1,1'b0, 1'b1,8'h34,2'd3,1'b1,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h41,2'd0,1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h42,2'd1,1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h43,2'd2,1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h44,2'd3,1'b1,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h51,2'd0,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h52,2'd1,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h53,2'd2,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h54,2'd3,1'b1,1'b0,1'b1,1'b0);
        // ---- reset mid-drain, then a fresh vector from rank 0 ----
        add(1'b0,1'b1,8'h61,8'h62,8'h63,8'h64,1'b1,1'b0, 1'b0,8'h00,2'd0,1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h61,2'd0,1'b0,1'b1,1'b1,1'b0);
        add(1'b1,1'b1,8'h99,8'h98,8'h97,8'h96,1'b1,1'b0, 1'b1,8'h62,2'd1,1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b1,8'h71,8'h72,8'h73,8'h74,1'b1,1'b0, 1'b0,8'h00,2'd0,1'b0,1'b0,1'b0,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h71,2'd0,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h72,2'd1,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h73,2'd2,1'b0,1'b0,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0, 1'b1,8'h74,2'd3,1'b1,1'b0,1'b1,1'b0);
        // ---- drop together with clear: set wins, then clear ----
        add(1'b0,1'b1,8'h81,8'h82,8'h83,8'h84,1'b0,1'b0, 1'b0,8'h00,2'd0,1'b0,1'b1,1'b0,1'b0);
        add(1'b0,1'b1,8'h91,8'h92,8'h93,8'h94,1'b0,1'b0, 1'b1,8'h81,2'd0,1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b1,8'hE1,8'hE2,8'hE3,8'hE4,1'b0,1'b1, 1'b1,8'h81,2'd0,1'b0,1'b1,1'b1,1'b0);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b0,1'b1, 1'b1,8'h81,2'd0,1'b0,1'b1,1'b1,1'b1);
        add(1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,1'b0,1'b0, 1'b1,8'h81,2'd0,1'b0,1'b1,1'b1,1'b0);

        // Apply table: at each falling edge check current outputs, then drive.
        foreach (tbl[i]) begin
            @(negedge clk);
            chk_out(i, tbl[i].ev, tbl[i].ey, tbl[i].er, tbl[i].el,
                    tbl[i].eid, tbl[i].eb, tbl[i].eo);
            rst = tbl[i].rst;
            vv  = tbl[i].vv;
            x   = mkx(tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].x3);
            rdy = tbl[i].rdy;
            clr = tbl[i].clr;
        end

        // ---- streaming: one vector every four cycles, ready held high ----
        @(negedge clk);
        rst = 1'b1; vv = 1'b0; clr = 1'b0; rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_out(1000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c <= 25; c++) begin
            if (c > 0) @(negedge clk);
            if (c >= 1 && c <= 24) begin
                int v, k;
                v = (c - 1) / 4;
                k = (c - 1) % 4;
                chk_out(2000 + c, 1'b1, 8'((v * 16) + k + 1), 2'(k), (k == 3),
                        1'(v % 2), 1'b1, 1'b0);
            end else if (c == 25) begin
                chk_out(2000 + c, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            if ((c % 4 == 0) && (c / 4 < 6)) begin
                vv = 1'b1;
                x  = mkx(8'(c * 4 + 1), 8'(c * 4 + 2), 8'(c * 4 + 3), 8'(c * 4 + 4));
            end else begin
                vv = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
